// File: rtl/iir_output_capture.sv
// Captures a window of filter output samples into a buffer after skipping a programmable settle count.
// Latency: start to done is 1 + skip + N cycles; readback data lags rd_addr by one cycle.
// Backpressure: none; in_data is consumed every cycle, and start is ignored while SKIP or CAPTURE is active.
module iir_output_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int SKIP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SKIP_W-1:0]     skip_count,
    input  logic [ADDR_W:0]       num_samples,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       sample_count,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_N  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [SKIP_W-1:0] SKIP_ONE = SKIP_W'(1);

    state_t                state;
    logic [SKIP_W-1:0]     skip_cnt;
    logic [ADDR_W:0]       n_lat;
    logic [ADDR_W:0]       n_eff;
    logic                  start_ok;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // abort outranks start, and a start is only honoured when no capture is in flight
    assign start_ok = start && !abort && (state == IDLE || state == DONE);
    assign wr_en    = (state == CAPTURE) && !abort && !rst;
    assign n_eff    = (num_samples == '0 || num_samples > DEPTH_N) ? DEPTH_N : num_samples;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
            skip_cnt     <= '0;
            n_lat        <= DEPTH_N;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start_ok) begin
            skip_cnt     <= skip_count;
            n_lat        <= n_eff;
            sample_count <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            state        <= (skip_count == '0) ? CAPTURE : SKIP;
        end else begin
            case (state)
                SKIP: begin
                    skip_cnt <= skip_cnt - SKIP_ONE;
                    if (skip_cnt == SKIP_ONE) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sample_count <= sample_count + CNT_ONE;
                    if (sample_count + CNT_ONE == n_lat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // sample_count stays below n_lat <= DEPTH while capturing, so the low bits never wrap
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[sample_count[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
